k423_wb_queue: RTL and testbench

//  Parametrised write-back stage with an in-order completion queue; successor to the single-slot WB stage.

---
 rtl/k423_wb_pkg.sv | 34 +++
 rtl/k423_wb_queue_if.sv | 49 ++++
 rtl/k423_load_align.sv | 32 +++
 rtl/k423_wb_queue.sv | 157 +++++++++++++++
 tb/tb_k423_wb_queue.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/k423_wb_pkg.sv
// Shared types for the write-back completion queue: load sizes, per-entry load info and status flags.
package k423_wb_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } load_size_e;

    typedef struct packed {
        load_size_e size;
        logic       uns;
        logic [2:0] off;
    } load_info_t;

    typedef struct packed {
        logic done;
        logic pend;
        logic lmis;
        logic lerr;
    } entry_flags_t;

    // DWORD has no natural alignment on a 32-bit datapath, so it always traps there.
    function automatic logic is_misaligned(input load_size_e size, input logic [2:0] addr, input logic is64);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return addr[0];
            WORD:    return |addr[1:0];
            default: return ~is64 | (|addr[2:0]);
        endcase
    endfunction

endpackage

// File: rtl/k423_wb_queue_if.sv
// EX / memory-response / write-back bundle of the completion queue.
interface k423_wb_queue_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 5
);
    logic              flush_i;
    logic              ex_vld_i;
    logic              ex_rdy_o;
    logic [ADDR_W-1:0] ex_pc_i;
    logic              ex_rd_vld_i;
    logic [IDX_W-1:0]  ex_rd_idx_i;
    logic [XLEN-1:0]   ex_rd_i;
    logic              ex_load_i;
    logic [1:0]        ex_load_size_i;
    logic              ex_load_unsigned_i;
    logic [ADDR_W-1:0] ex_load_addr_i;
    logic              ex_br_tkn_i;
    logic [ADDR_W-1:0] ex_br_pc_i;
    logic              mem_rsp_vld_i;
    logic [XLEN-1:0]   mem_rsp_rdata_i;
    logic              mem_rsp_err_i;
    logic              wb_vld_o;
    logic              wb_rdy_i;
    logic [ADDR_W-1:0] wb_pc_o;
    logic              wb_rd_vld_o;
    logic [IDX_W-1:0]  wb_rd_idx_o;
    logic [XLEN-1:0]   wb_rd_o;
    logic              wb_br_tkn_o;
    logic [ADDR_W-1:0] wb_br_pc_o;
    logic              wb_lmis_o;
    logic              wb_lerr_o;

    modport slave (
        input  flush_i, ex_vld_i, ex_pc_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_i, ex_load_i,
               ex_load_size_i, ex_load_unsigned_i, ex_load_addr_i, ex_br_tkn_i, ex_br_pc_i,
               mem_rsp_vld_i, mem_rsp_rdata_i, mem_rsp_err_i, wb_rdy_i,
        output ex_rdy_o, wb_vld_o, wb_pc_o, wb_rd_vld_o, wb_rd_idx_o, wb_rd_o, wb_br_tkn_o,
               wb_br_pc_o, wb_lmis_o, wb_lerr_o
    );

    modport master (
        output flush_i, ex_vld_i, ex_pc_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_i, ex_load_i,
               ex_load_size_i, ex_load_unsigned_i, ex_load_addr_i, ex_br_tkn_i, ex_br_pc_i,
               mem_rsp_vld_i, mem_rsp_rdata_i, mem_rsp_err_i, wb_rdy_i,
        input  ex_rdy_o, wb_vld_o, wb_pc_o, wb_rd_vld_o, wb_rd_idx_o, wb_rd_o, wb_br_tkn_o,
               wb_br_pc_o, wb_lmis_o, wb_lerr_o
    );
endinterface

// File: rtl/k423_load_align.sv
// Shifts the load bytes down to bit 0, truncates to the access size and sign/zero extends.
module k423_load_align
    import k423_wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] off,
    input  load_size_e       size,
    input  logic             uns,
    output logic [XLEN-1:0]  data
);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;
    int              width;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (size)
            BYTE:    width = 8;
            HALF:    width = 16;
            WORD:    width = 32;
            default: width = XLEN;
        endcase
        mask = {XLEN{1'b1}} >> (XLEN - width);
        // Top bit of the field is where mask and mask>>1 differ.
        sign = ~uns & (|(shifted & (mask ^ (mask >> 1))));
        data = (shifted & mask) | ({XLEN{sign}} & ~mask);
    end
endmodule

// File: rtl/k423_wb_queue.sv
// In-order write-back completion queue: EX results wait here until done, loads complete on memory responses.
module k423_wb_queue
    import k423_wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 5,
    parameter int DEPTH  = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    k423_wb_queue_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DROP_W = CNT_W + 3;
    localparam int OFF_W  = (XLEN == 64) ? 3 : 2;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              rd_vld;
        logic [IDX_W-1:0]  rd_idx;
        logic [XLEN-1:0]   rd;
        logic              br_tkn;
        logic [ADDR_W-1:0] br_pc;
        load_info_t        ld;
        entry_flags_t      st;
    } wb_entry_t;

    wb_entry_t          q [DEPTH];
    wb_entry_t          q_n [DEPTH];
    wb_entry_t          new_e, head_n, out_q;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n, rsp_idx, idx;
    logic [CNT_W-1:0]   count, count_n, npend;
    logic [DROP_W-1:0]  drop_cnt, drop_n;
    logic               wb_vld_q, wb_vld_n, push, pop, found, mis, rsp_hit;
    logic [XLEN-1:0]    rsp_data;
    logic               unused_addr;

    assign unused_addr  = ^bus.ex_load_addr_i[ADDR_W-1:3];
    assign bus.ex_rdy_o = (count < CNT_W'(DEPTH)) & ~bus.flush_i;
    assign push         = bus.ex_vld_i & bus.ex_rdy_o;
    assign pop          = wb_vld_q & bus.wb_rdy_i;
    assign rsp_hit      = bus.mem_rsp_vld_i & ((drop_cnt != '0) | found);

    always_comb begin
        mis   = bus.ex_load_i & is_misaligned(load_size_e'(bus.ex_load_size_i),
                                              bus.ex_load_addr_i[2:0], XLEN == 64);
        new_e           = '0;
        new_e.pc        = bus.ex_pc_i;
        new_e.rd_vld    = bus.ex_rd_vld_i & ~mis;
        new_e.rd_idx    = bus.ex_rd_idx_i;
        new_e.rd        = bus.ex_rd_i;
        new_e.br_tkn    = bus.ex_br_tkn_i;
        new_e.br_pc     = bus.ex_br_pc_i;
        new_e.ld.size   = load_size_e'(bus.ex_load_size_i);
        new_e.ld.uns    = bus.ex_load_unsigned_i;
        new_e.ld.off    = bus.ex_load_addr_i[2:0];
        new_e.st.done   = ~bus.ex_load_i | mis;
        new_e.st.pend   = bus.ex_load_i & ~mis;
        new_e.st.lmis   = mis;
    end

    // Responses arrive in issue order, so the oldest pending slot from the head is the target.
    always_comb begin
        found   = 1'b0;
        rsp_idx = rd_ptr;
        npend   = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx   = rd_ptr + PTR_W'(i);
            npend = npend + CNT_W'(q[i].st.pend);
            if (!found && q[idx].st.pend) begin
                found   = 1'b1;
                rsp_idx = idx;
            end
        end
    end

    k423_load_align #(.XLEN(XLEN)) u_align (
        .rdata (bus.mem_rsp_rdata_i),
        .off   (q[rsp_idx].ld.off[OFF_W-1:0]),
        .size  (q[rsp_idx].ld.size),
        .uns   (q[rsp_idx].ld.uns),
        .data  (rsp_data)
    );

    always_comb begin
        q_n      = q;
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        count_n  = count;
        drop_n   = drop_cnt;
        if (bus.flush_i) begin
            for (int i = 0; i < DEPTH; i++) q_n[i].st = '0;
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            count_n  = '0;
            // Outstanding drops from an earlier flush are kept; a response in this cycle retires one of them.
            drop_n   = drop_cnt + DROP_W'(npend) - DROP_W'(rsp_hit);
        end else begin
            if (bus.mem_rsp_vld_i && drop_cnt != '0) begin
                drop_n = drop_cnt - 1'b1;
            end else if (bus.mem_rsp_vld_i && found) begin
                q_n[rsp_idx].rd      = rsp_data;
                q_n[rsp_idx].rd_vld  = q[rsp_idx].rd_vld & ~bus.mem_rsp_err_i;
                q_n[rsp_idx].st.lerr = bus.mem_rsp_err_i;
                q_n[rsp_idx].st.pend = 1'b0;
                q_n[rsp_idx].st.done = 1'b1;
            end
            if (pop) begin
                q_n[rd_ptr].st.done = 1'b0;
                rd_ptr_n            = rd_ptr + 1'b1;
            end
            if (push) begin
                q_n[wr_ptr] = new_e;
                wr_ptr_n    = wr_ptr + 1'b1;
            end
            count_n = count + CNT_W'(push) - CNT_W'(pop);
        end
        head_n   = q_n[rd_ptr_n];
        wb_vld_n = (count_n != '0) & head_n.st.done;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            wb_vld_q <= 1'b0;
            out_q    <= '0;
        end else begin
            q        <= q_n;
            rd_ptr   <= rd_ptr_n;
            wr_ptr   <= wr_ptr_n;
            count    <= count_n;
            drop_cnt <= drop_n;
            wb_vld_q <= wb_vld_n;
            out_q    <= wb_vld_n ? head_n : '0;
        end
    end

    assign bus.wb_vld_o    = wb_vld_q;
    assign bus.wb_pc_o     = out_q.pc;
    assign bus.wb_rd_vld_o = out_q.rd_vld;
    assign bus.wb_rd_idx_o = out_q.rd_idx;
    assign bus.wb_rd_o     = out_q.rd;
    assign bus.wb_br_tkn_o = out_q.br_tkn;
    assign bus.wb_br_pc_o  = out_q.br_pc;
    assign bus.wb_lmis_o   = out_q.st.lmis;
    assign bus.wb_lerr_o   = out_q.st.lerr;

    unused_rsp_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.mem_rsp_vld_i && !bus.flush_i && drop_cnt == '0) |-> found);
endmodule

// File: tb/tb_k423_wb_queue.sv
// Directed bench for the write-back completion queue at XLEN 32 and 64.
module tb_k423_wb_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    k423_wb_queue_if #(.XLEN(32)) b32 ();
    k423_wb_queue_if #(.XLEN(64)) b64 ();

    k423_wb_queue #(.XLEN(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
    k423_wb_queue #(.XLEN(64)) dut64 (.clk_i(clk), .rst_i(rst), .bus(b64));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        b32.flush_i = 0; b32.ex_vld_i = 0; b32.ex_pc_i = '0; b32.ex_rd_vld_i = 0;
        b32.ex_rd_idx_i = '0; b32.ex_rd_i = '0; b32.ex_load_i = 0; b32.ex_load_size_i = '0;
        b32.ex_load_unsigned_i = 0; b32.ex_load_addr_i = '0; b32.ex_br_tkn_i = 0;
        b32.ex_br_pc_i = '0; b32.mem_rsp_vld_i = 0; b32.mem_rsp_rdata_i = '0; b32.mem_rsp_err_i = 0;
    endtask

    task automatic idle64();
        b64.flush_i = 0; b64.ex_vld_i = 0; b64.ex_pc_i = '0; b64.ex_rd_vld_i = 0;
        b64.ex_rd_idx_i = '0; b64.ex_rd_i = '0; b64.ex_load_i = 0; b64.ex_load_size_i = '0;
        b64.ex_load_unsigned_i = 0; b64.ex_load_addr_i = '0; b64.ex_br_tkn_i = 0;
        b64.ex_br_pc_i = '0; b64.mem_rsp_vld_i = 0; b64.mem_rsp_rdata_i = '0; b64.mem_rsp_err_i = 0;
    endtask

    task automatic load32(input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [4:0] rd);
        b32.ex_vld_i = 1; b32.ex_load_i = 1; b32.ex_rd_vld_i = 1; b32.ex_rd_idx_i = rd;
        b32.ex_load_size_i = size; b32.ex_load_unsigned_i = uns; b32.ex_load_addr_i = addr;
        b32.ex_pc_i = 32'h300; b32.ex_rd_i = '0; b32.ex_br_tkn_i = 0;
    endtask

    task automatic alu32(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
        b32.ex_vld_i = 1; b32.ex_load_i = 0; b32.ex_rd_vld_i = 1; b32.ex_rd_idx_i = rd;
        b32.ex_rd_i = val; b32.ex_pc_i = pc; b32.ex_br_tkn_i = 1; b32.ex_br_pc_i = pc + 32'h40;
    endtask

    task automatic rsp32(input logic [31:0] d, input logic err);
        b32.mem_rsp_vld_i = 1; b32.mem_rsp_rdata_i = d; b32.mem_rsp_err_i = err;
    endtask

    task automatic test_reset();
        idle32(); idle64();
        b32.wb_rdy_i = 1; b64.wb_rdy_i = 1;
        rst = 1;
        cyc(); cyc();
        rst = 0;
        #1;
        chk++; if (b32.wb_vld_o !== 1'b0) begin errs++; $display("FAIL reset_vld32: got %b want 0", b32.wb_vld_o); end
        chk++; if (b32.ex_rdy_o !== 1'b1) begin errs++; $display("FAIL reset_rdy32: got %b want 1", b32.ex_rdy_o); end
        chk++; if (b32.wb_rd_o !== 32'h0) begin errs++; $display("FAIL reset_rd32: got %h want 0", b32.wb_rd_o); end
        chk++; if (b64.wb_vld_o !== 1'b0) begin errs++; $display("FAIL reset_vld64: got %b want 0", b64.wb_vld_o); end
    endtask

    task automatic test_alu();
        alu32(5'd5, 32'h1234, 32'h100);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1) begin errs++; $display("FAIL alu_vld: got %b want 1", b32.wb_vld_o); end
        chk++; if (b32.wb_rd_o !== 32'h1234) begin errs++; $display("FAIL alu_rd: got %h want 1234", b32.wb_rd_o); end
        chk++; if (b32.wb_rd_idx_o !== 5'd5) begin errs++; $display("FAIL alu_idx: got %0d want 5", b32.wb_rd_idx_o); end
        chk++; if (b32.wb_br_pc_o !== 32'h140 || b32.wb_br_tkn_o !== 1'b1) begin errs++; $display("FAIL alu_br: got %h/%b want 140/1", b32.wb_br_pc_o, b32.wb_br_tkn_o); end
        cyc();
        chk++; if (b32.wb_vld_o !== 1'b0) begin errs++; $display("FAIL alu_pop: got %b want 0", b32.wb_vld_o); end
    endtask

    task automatic test_load_ext();
        load32(2'd0, 1'b0, 32'h3, 5'd7);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b0) begin errs++; $display("FAIL lb_pending: got %b want 0", b32.wb_vld_o); end
        rsp32(32'h80FF_0000, 1'b0);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_rd_o !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_signed: got %b/%h want 1/ffffff80", b32.wb_vld_o, b32.wb_rd_o); end
        chk++; if (b32.wb_rd_idx_o !== 5'd7 || b32.wb_rd_vld_o !== 1'b1) begin errs++; $display("FAIL lb_idx: got %0d/%b want 7/1", b32.wb_rd_idx_o, b32.wb_rd_vld_o); end
        load32(2'd0, 1'b1, 32'h3, 5'd8);
        cyc();
        idle32();
        rsp32(32'h80FF_0000, 1'b0);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_rd_o !== 32'h0000_0080) begin errs++; $display("FAIL lbu: got %b/%h want 1/00000080", b32.wb_vld_o, b32.wb_rd_o); end
        cyc();
    endtask

    task automatic test_two_loads();
        load32(2'd2, 1'b0, 32'h40, 5'd1);
        cyc();
        load32(2'd2, 1'b0, 32'h44, 5'd2);
        cyc();
        idle32();
        chk++; if (b32.ex_rdy_o !== 1'b0) begin errs++; $display("FAIL full_rdy: got %b want 0", b32.ex_rdy_o); end
        cyc(); cyc();
        rsp32(32'h1111_1111, 1'b0);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_rd_idx_o !== 5'd1 || b32.wb_rd_o !== 32'h1111_1111) begin errs++; $display("FAIL first_ret: got %b/%0d/%h want 1/1/11111111", b32.wb_vld_o, b32.wb_rd_idx_o, b32.wb_rd_o); end
        chk++; if (b32.ex_rdy_o !== 1'b0) begin errs++; $display("FAIL still_full: got %b want 0", b32.ex_rdy_o); end
        cyc();
        chk++; if (b32.wb_vld_o !== 1'b0 || b32.ex_rdy_o !== 1'b1) begin errs++; $display("FAIL after_pop: got vld %b rdy %b want 0/1", b32.wb_vld_o, b32.ex_rdy_o); end
        cyc();
        rsp32(32'h2222_2222, 1'b0);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_rd_idx_o !== 5'd2 || b32.wb_rd_o !== 32'h2222_2222) begin errs++; $display("FAIL second_ret: got %b/%0d/%h want 1/2/22222222", b32.wb_vld_o, b32.wb_rd_idx_o, b32.wb_rd_o); end
        cyc();
    endtask

    task automatic test_misaligned();
        b32.wb_rdy_i = 0;
        load32(2'd1, 1'b0, 32'h201, 5'd3);
        b32.ex_pc_i = 32'h200;
        cyc();
        alu32(5'd4, 32'hABCD, 32'h204);
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_lmis_o !== 1'b1 || b32.wb_rd_vld_o !== 1'b0) begin errs++; $display("FAIL lh_mis: got %b/%b/%b want 1/1/0", b32.wb_vld_o, b32.wb_lmis_o, b32.wb_rd_vld_o); end
        cyc();
        idle32();
        chk++; if (b32.wb_lmis_o !== 1'b1 || b32.wb_pc_o !== 32'h200) begin errs++; $display("FAIL stall_hold: got %b/%h want 1/200", b32.wb_lmis_o, b32.wb_pc_o); end
        b32.wb_rdy_i = 1;
        cyc();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_rd_o !== 32'hABCD || b32.wb_lmis_o !== 1'b0 || b32.wb_rd_idx_o !== 5'd4) begin errs++; $display("FAIL alu_after_mis: got %b/%h/%b/%0d want 1/abcd/0/4", b32.wb_vld_o, b32.wb_rd_o, b32.wb_lmis_o, b32.wb_rd_idx_o); end
        cyc();
        chk++; if (b32.wb_vld_o !== 1'b0) begin errs++; $display("FAIL mis_drain: got %b want 0", b32.wb_vld_o); end
        load32(2'd3, 1'b0, 32'h0, 5'd6);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_lmis_o !== 1'b1) begin errs++; $display("FAIL ld_on_32: got %b/%b want 1/1", b32.wb_vld_o, b32.wb_lmis_o); end
        cyc();
    endtask

    task automatic test_flush();
        load32(2'd2, 1'b0, 32'h0, 5'd1);
        cyc();
        load32(2'd2, 1'b0, 32'h4, 5'd2);
        cyc();
        idle32();
        b32.flush_i = 1;
        #1;
        chk++; if (b32.ex_rdy_o !== 1'b0) begin errs++; $display("FAIL flush_rdy: got %b want 0", b32.ex_rdy_o); end
        cyc();
        b32.flush_i = 0;
        #1;
        chk++; if (b32.wb_vld_o !== 1'b0 || b32.ex_rdy_o !== 1'b1) begin errs++; $display("FAIL flush_empty: got vld %b rdy %b want 0/1", b32.wb_vld_o, b32.ex_rdy_o); end
        load32(2'd2, 1'b0, 32'h80, 5'd9);
        cyc();
        idle32();
        rsp32(32'hDEAD_0001, 1'b0);
        cyc();
        chk++; if (b32.wb_vld_o !== 1'b0) begin errs++; $display("FAIL drop1: got %b want 0", b32.wb_vld_o); end
        rsp32(32'hDEAD_0002, 1'b0);
        cyc();
        chk++; if (b32.wb_vld_o !== 1'b0) begin errs++; $display("FAIL drop2: got %b want 0", b32.wb_vld_o); end
        rsp32(32'h5555_AAAA, 1'b0);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_rd_o !== 32'h5555_AAAA || b32.wb_rd_idx_o !== 5'd9) begin errs++; $display("FAIL post_flush: got %b/%h/%0d want 1/5555aaaa/9", b32.wb_vld_o, b32.wb_rd_o, b32.wb_rd_idx_o); end
        cyc();
    endtask

    task automatic test_bus_error();
        load32(2'd2, 1'b0, 32'h10, 5'd6);
        cyc();
        idle32();
        rsp32(32'h1234_5678, 1'b1);
        cyc();
        idle32();
        chk++; if (b32.wb_vld_o !== 1'b1 || b32.wb_lerr_o !== 1'b1 || b32.wb_rd_vld_o !== 1'b0) begin errs++; $display("FAIL bus_err: got %b/%b/%b want 1/1/0", b32.wb_vld_o, b32.wb_lerr_o, b32.wb_rd_vld_o); end
        cyc();
    endtask

    task automatic test_xlen64();
        b64.ex_vld_i = 1; b64.ex_load_i = 1; b64.ex_rd_vld_i = 1; b64.ex_rd_idx_i = 5'd10;
        b64.ex_load_size_i = 2'd3; b64.ex_load_unsigned_i = 0; b64.ex_load_addr_i = 32'h8;
        cyc();
        idle64();
        b64.mem_rsp_vld_i = 1; b64.mem_rsp_rdata_i = 64'h8000_0000_0000_0001;
        cyc();
        idle64();
        chk++; if (b64.wb_vld_o !== 1'b1 || b64.wb_rd_o !== 64'h8000_0000_0000_0001 || b64.wb_lmis_o !== 1'b0) begin errs++; $display("FAIL ld64: got %b/%h/%b want 1/8000000000000001/0", b64.wb_vld_o, b64.wb_rd_o, b64.wb_lmis_o); end
        b64.ex_vld_i = 1; b64.ex_load_i = 1; b64.ex_rd_vld_i = 1; b64.ex_rd_idx_i = 5'd11;
        b64.ex_load_size_i = 2'd2; b64.ex_load_unsigned_i = 1; b64.ex_load_addr_i = 32'h4;
        cyc();
        idle64();
        b64.mem_rsp_vld_i = 1; b64.mem_rsp_rdata_i = 64'h8000_0000_1234_5678;
        cyc();
        idle64();
        chk++; if (b64.wb_vld_o !== 1'b1 || b64.wb_rd_o !== 64'h0000_0000_8000_0000) begin errs++; $display("FAIL lwu64: got %b/%h want 1/0000000080000000", b64.wb_vld_o, b64.wb_rd_o); end
        b64.ex_vld_i = 1; b64.ex_load_i = 1; b64.ex_rd_vld_i = 1; b64.ex_rd_idx_i = 5'd12;
        b64.ex_load_size_i = 2'd2; b64.ex_load_unsigned_i = 0; b64.ex_load_addr_i = 32'h4;
        cyc();
        idle64();
        b64.mem_rsp_vld_i = 1; b64.mem_rsp_rdata_i = 64'h8000_0000_1234_5678;
        cyc();
        idle64();
        chk++; if (b64.wb_rd_o !== 64'hFFFF_FFFF_8000_0000 || b64.wb_rd_idx_o !== 5'd12) begin errs++; $display("FAIL lw64: got %h/%0d want ffffffff80000000/12", b64.wb_rd_o, b64.wb_rd_idx_o); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_two_loads();
        test_misaligned();
        test_flush();
        test_bus_error();
        test_xlen64();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
        $finish;
    end
endmodule
